// File: rtl/timer_arb_pkg.sv
`default_nettype none
// ============================================================================
// timer_arb_pkg : FSM encoding and default sizing for timer_arbiter
// Revision 1.0
// ============================================================================
package timer_arb_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 4;

endpackage
`default_nettype wire

// File: rtl/timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// timer_arbiter_if : request/grant bundle between clients and timer_arbiter
// Revision 1.0
// ============================================================================
interface timer_arbiter_if #(
    parameter int N_REQ = timer_arb_pkg::N_REQ_DEF,
    parameter int W     = timer_arb_pkg::W_DEF
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] delay;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic [W-1:0]       cnt;

    modport master (
        output req, delay,
        input  grant, done, busy, cnt
    );

    modport slave (
        input  req, delay,
        output grant, done, busy, cnt
    );
endinterface
`default_nettype wire

// File: rtl/timer_arbiter_down_cnt.sv
`default_nettype none
// ============================================================================
// down_cnt : loadable W-bit down-counter that saturates at zero
// Revision 1.0
// ============================================================================
module down_cnt #(
    parameter int W = timer_arb_pkg::W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= d_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign q_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// timer_arbiter : round-robin owner of one shared down-counter
// Revision 1.0
// ============================================================================
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    win_q, win_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [IW-1:0]    rr_win;
    logic             win_req;
    logic [W-1:0]     win_delay;
    logic [W-1:0]     cnt;
    logic             cnt_load;
    logic             cnt_en;

    // Search starts one past the last owner so it becomes lowest priority.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        rr_win    = rr_pick(bus.req, ptr_q);
        win_req   = bus.req[win_q];
        win_delay = bus.delay[win_q*W +: W];
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (|bus.req) begin
                    win_d   = rr_win;
                    ptr_d   = rr_win;
                    grant_d = N_REQ'(1) << rr_win;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!win_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A dropped request wins over completion, even at zero.
                if (!win_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (cnt == '0) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign cnt_load = (state_q == ST_LOAD) && win_req;
    assign cnt_en   = (state_q == ST_RUN) && win_req && (cnt != '0);

    down_cnt #(.W(W)) u_down_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .d_i    (win_delay),
        .q_o    (cnt)
    );

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.cnt   = cnt;
endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_timer_arbiter : directed stimulus, per-cycle reference model, literal pins
// Revision 1.0
// ============================================================================
module tb_timer_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    timer_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: owner plus age in cycles since its grant edge.
    int   m_owner = -1;
    int   m_age   = 0;
    int   m_d     = 0;
    int   m_ptr   = N - 1;
    int   m_cnt   = 0;
    int   m_idx   = 0;
    bit   m_done  = 1'b0;
    bit   m_found = 1'b0;
    bit   started = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_cnt   = 0;
            m_done  = 1'b0;
        end else if (m_owner < 0) begin
            m_done = 1'b0;
            if (bus.req != '0) begin
                m_found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    m_idx = (m_ptr + i) % N;
                    if (!m_found && bus.req[m_idx]) begin
                        m_owner = m_idx;
                        m_found = 1'b1;
                    end
                end
                m_ptr = m_owner;
                m_age = 0;
                m_d   = int'(bus.delay[m_owner*W +: W]);
            end
        end else begin
            m_age++;
            if (m_age == m_d + 3) begin
                m_owner = -1;
                m_done  = 1'b0;
            end else if (!bus.req[m_owner]) begin
                m_owner = -1;
            end else begin
                m_cnt  = (m_d - (m_age - 1) > 0) ? (m_d - (m_age - 1)) : 0;
                m_done = (m_age == m_d + 2);
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_done",  32'(bus.done),  (m_done && m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("model_busy",  32'(bus.busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
            check("model_cnt",   32'(bus.cnt),   32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_delay(input int i, input int d);
        bus.delay[i*W +: W] = W'(d);
    endtask

    int         order[$];
    logic [N-1:0] prev_grant;
    int         exp_order [5] = '{0, 1, 2, 3, 0};
    int         budget;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '1;
        for (int i = 0; i < N; i++) set_delay(i, 5);
        rst_n = 1'b0;
        ticks(2);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_done",  32'(bus.done),  32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_cnt",   32'(bus.cnt),   32'h0);
        rst_n = 1'b1;
        tick();
        check("rst_first_grant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        ticks(3);

        // Single requester, delay 5
        set_delay(2, 5);
        bus.req = 4'b0100;
        tick();
        check("single_e0_grant", 32'(bus.grant), 32'h4);
        tick();
        check("single_e1_cnt", 32'(bus.cnt), 32'd5);
        ticks(5);
        check("single_e6_cnt", 32'(bus.cnt), 32'd0);
        tick();
        check("single_e7_done", 32'(bus.done), 32'h4);
        tick();
        check("single_e8_grant", 32'(bus.grant), 32'h0);
        check("single_e8_done",  32'(bus.done),  32'h0);
        bus.req = '0;
        ticks(2);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Fairness with all requesters held
        for (int i = 0; i < N; i++) set_delay(i, 1);
        bus.req    = 4'b1111;
        prev_grant = '0;
        budget     = 0;
        while (order.size() < 5 && budget < 80) begin
            tick();
            budget++;
            if (bus.grant != '0 && prev_grant == '0) begin
                for (int i = 0; i < N; i++) if (bus.grant[i]) order.push_back(i);
            end
            prev_grant = bus.grant;
        end
        bus.req = '0;
        check("fair_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check("fair_order", 32'(order[i]), 32'(exp_order[i]));
        end
        ticks(3);

        // Zero delay
        set_delay(1, 0);
        bus.req = 4'b0010;
        tick();
        check("zero_e0_grant", 32'(bus.grant), 32'h2);
        tick();
        check("zero_e1_cnt", 32'(bus.cnt), 32'd0);
        tick();
        check("zero_e2_done", 32'(bus.done), 32'h2);
        tick();
        check("zero_e3_grant", 32'(bus.grant), 32'h0);
        bus.req = '0;
        ticks(2);

        // Maximum delay
        set_delay(2, 15);
        bus.req = 4'b0100;
        tick();
        ticks(16);
        check("max_e16_cnt", 32'(bus.cnt), 32'd0);
        tick();
        check("max_e17_done", 32'(bus.done), 32'h4);
        check("max_e17_cnt",  32'(bus.cnt),  32'd0);
        tick();
        bus.req = '0;
        ticks(2);

        // Abort mid-run, then the waiting requester wins
        set_delay(1, 5);
        set_delay(3, 2);
        bus.req = 4'b0010;
        tick();
        check("abort_e0_grant", 32'(bus.grant), 32'h2);
        ticks(3);
        check("abort_e3_cnt", 32'(bus.cnt), 32'd3);
        bus.req = 4'b1000;
        tick();
        check("abort_grant", 32'(bus.grant), 32'h0);
        check("abort_busy",  32'(bus.busy),  32'h0);
        check("abort_cnt",   32'(bus.cnt),   32'd3);
        check("abort_done",  32'(bus.done),  32'h0);
        tick();
        check("abort_next_grant", 32'(bus.grant), 32'h8);
        budget = 0;
        while (bus.done == '0 && budget < 20) begin
            tick();
            budget++;
        end
        check("abort_next_done", 32'(bus.done), 32'h8);
        tick();
        bus.req = '0;
        ticks(2);

        // Reset in the middle of a countdown
        set_delay(2, 8);
        bus.req = 4'b0100;
        tick();
        ticks(5);
        check("rstmid_cnt", 32'(bus.cnt), 32'd4);
        rst_n = 1'b0;
        tick();
        check("rstmid_grant", 32'(bus.grant), 32'h0);
        check("rstmid_done",  32'(bus.done),  32'h0);
        check("rstmid_busy",  32'(bus.busy),  32'h0);
        check("rstmid_cnt",   32'(bus.cnt),   32'h0);
        rst_n = 1'b1;
        set_delay(0, 2);
        set_delay(3, 2);
        bus.req = 4'b1101;
        tick();
        check("rstmid_next_grant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        ticks(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
